// File: rtl/tb_run_ctrl_if.sv
// Bus between the run controller and the bench top level: start/budget,
// core wrapper completion indications, and the sequenced DUT controls/status.
interface tb_run_ctrl_if #(
   parameter int unsigned CNT_WIDTH = 32
);
   logic                 start_i;
   logic [CNT_WIDTH-1:0] max_cycles_i;
   logic                 tests_passed_i;
   logic                 tests_failed_i;
   logic                 exit_valid_i;
   logic [31:0]          exit_value_i;
   logic                 dut_rst_no;
   logic                 fetch_enable_o;
   logic                 done_o;
   logic [2:0]           status_o;
   logic [31:0]          exit_value_o;
   logic [CNT_WIDTH-1:0] cycle_cnt_o;

   // The controller receives the requests and wrapper indications.
   modport slave (
      input  start_i, max_cycles_i, tests_passed_i, tests_failed_i,
             exit_valid_i, exit_value_i,
      output dut_rst_no, fetch_enable_o, done_o, status_o, exit_value_o,
             cycle_cnt_o
   );

   modport master (
      output start_i, max_cycles_i, tests_passed_i, tests_failed_i,
             exit_valid_i, exit_value_i,
      input  dut_rst_no, fetch_enable_o, done_o, status_o, exit_value_o,
             cycle_cnt_o
   );
endinterface

// File: rtl/tb_run_ctrl.sv
// Run controller: sequences DUT reset and fetch enable after a start request,
// then latches a single completion status from wrapper events or a cycle budget.
module tb_run_ctrl #(
   parameter int unsigned RESET_WAIT_CYCLES = 4,
   parameter int unsigned FETCH_DELAY       = 3,
   parameter int unsigned CNT_WIDTH         = 32
) (
   input  logic          core_clk,
   input  logic          core_rst_n,
   tb_run_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_RESET, ST_WAKE, ST_RUN, ST_DONE
   } state_e;

   localparam logic [2:0] STS_NONE     = 3'd0;
   localparam logic [2:0] STS_PASS     = 3'd1;
   localparam logic [2:0] STS_FAIL     = 3'd2;
   localparam logic [2:0] STS_EXIT_OK  = 3'd3;
   localparam logic [2:0] STS_EXIT_ERR = 3'd4;
   localparam logic [2:0] STS_TIMEOUT  = 3'd5;

   localparam logic [31:0] RW_LAST = 32'(RESET_WAIT_CYCLES - 1);
   localparam logic [31:0] FD_LAST = (FETCH_DELAY == 0) ? 32'd0 : 32'(FETCH_DELAY - 1);

   state_e               state_q, state_d;
   logic [31:0]          phase_q, phase_d;
   logic                 dut_rst_q, dut_rst_d;
   logic                 fetch_q, fetch_d;
   logic                 done_q, done_d;
   logic [2:0]           status_q, status_d;
   logic [31:0]          exit_q, exit_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] cnt_sat;
   logic                 timeout_hit;

   assign cnt_sat     = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
   assign timeout_hit = (bus.max_cycles_i != '0) &&
                        (cnt_q == bus.max_cycles_i - CNT_WIDTH'(1));

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state_q   <= ST_IDLE;
         phase_q   <= '0;
         dut_rst_q <= 1'b0;
         fetch_q   <= 1'b0;
         done_q    <= 1'b0;
         status_q  <= STS_NONE;
         exit_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         dut_rst_q <= dut_rst_d;
         fetch_q   <= fetch_d;
         done_q    <= done_d;
         status_q  <= status_d;
         exit_q    <= exit_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      dut_rst_d = dut_rst_q;
      fetch_d   = fetch_q;
      done_d    = done_q;
      status_d  = status_q;
      exit_d    = exit_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            fetch_d = 1'b0;
            if (state_q == ST_IDLE) dut_rst_d = 1'b0;
            if (bus.start_i) begin
               state_d   = ST_RESET;
               phase_d   = '0;
               dut_rst_d = 1'b0;
               done_d    = 1'b0;
               status_d  = STS_NONE;
               exit_d    = '0;
               cnt_d     = '0;
            end
         end
         ST_RESET: begin
            if (phase_q == RW_LAST) begin
               phase_d   = '0;
               dut_rst_d = 1'b1;
               if (FETCH_DELAY == 0) begin
                  state_d = ST_RUN;
                  fetch_d = 1'b1;
               end else begin
                  state_d = ST_WAKE;
               end
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         ST_WAKE: begin
            if (phase_q == FD_LAST) begin
               phase_d = '0;
               state_d = ST_RUN;
               fetch_d = 1'b1;
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_sat;
            // Wrapper events are checked before the budget so they win a tie.
            if (bus.tests_failed_i) begin
               status_d = STS_FAIL;
            end else if (bus.exit_valid_i && bus.exit_value_i != 32'd0) begin
               status_d = STS_EXIT_ERR;
               exit_d   = bus.exit_value_i;
            end else if (bus.tests_passed_i) begin
               status_d = STS_PASS;
            end else if (bus.exit_valid_i) begin
               status_d = STS_EXIT_OK;
            end else if (timeout_hit) begin
               status_d = STS_TIMEOUT;
            end
            if (status_d != STS_NONE) begin
               state_d = ST_DONE;
               fetch_d = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.dut_rst_no     = dut_rst_q;
   assign bus.fetch_enable_o = fetch_q;
   assign bus.done_o         = done_q;
   assign bus.status_o       = status_q;
   assign bus.exit_value_o   = exit_q;
   assign bus.cycle_cnt_o    = cnt_q;

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Directed bench for tb_run_ctrl: default-parameter instance plus a
// zero-fetch-delay instance sharing clock and reset.
module tb_tb_run_ctrl;

   logic core_clk   = 1'b0;
   logic core_rst_n = 1'b0;
   int   vectors    = 0;
   int   miscompares = 0;
   int   hi;

   always #5 core_clk = ~core_clk;

   tb_run_ctrl_if #(.CNT_WIDTH(32)) bus_a ();
   tb_run_ctrl_if #(.CNT_WIDTH(32)) bus_b ();

   tb_run_ctrl dut_a (
      .core_clk   (core_clk),
      .core_rst_n (core_rst_n),
      .bus        (bus_a)
   );

   tb_run_ctrl #(.RESET_WAIT_CYCLES(2), .FETCH_DELAY(0)) dut_b (
      .core_clk   (core_clk),
      .core_rst_n (core_rst_n),
      .bus        (bus_b)
   );

   task automatic tick;
      @(posedge core_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rst"},    64'(bus_a.dut_rst_no),     64'd0);
      chk({tag, "_fetch"},  64'(bus_a.fetch_enable_o), 64'd0);
      chk({tag, "_done"},   64'(bus_a.done_o),         64'd0);
      chk({tag, "_status"}, 64'(bus_a.status_o),       64'd0);
      chk({tag, "_exit"},   64'(bus_a.exit_value_o),   64'd0);
      chk({tag, "_cnt"},    64'(bus_a.cycle_cnt_o),    64'd0);
   endtask

   // Start pulse sampled at edge k; checks reset release at k+4, fetch at k+7.
   task automatic start_seq(input string tag);
      bus_a.start_i = 1'b1;
      tick;
      bus_a.start_i = 1'b0;
      chk({tag, "_clr_done"},   64'(bus_a.done_o),      64'd0);
      chk({tag, "_clr_status"}, 64'(bus_a.status_o),    64'd0);
      chk({tag, "_clr_cnt"},    64'(bus_a.cycle_cnt_o), 64'd0);
      repeat (3) begin
         tick;
         chk({tag, "_held_rst"}, 64'(bus_a.dut_rst_no), 64'd0);
      end
      tick;
      chk({tag, "_rst_rise"},   64'(bus_a.dut_rst_no),     64'd1);
      chk({tag, "_wake_fetch"}, 64'(bus_a.fetch_enable_o), 64'd0);
      repeat (2) begin
         tick;
         chk({tag, "_wake_fetch"}, 64'(bus_a.fetch_enable_o), 64'd0);
      end
      tick;
      chk({tag, "_fetch_rise"}, 64'(bus_a.fetch_enable_o), 64'd1);
      chk({tag, "_run_cnt0"},   64'(bus_a.cycle_cnt_o),    64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_a.start_i = 0; bus_a.max_cycles_i = 0; bus_a.tests_passed_i = 0;
      bus_a.tests_failed_i = 0; bus_a.exit_valid_i = 0; bus_a.exit_value_i = 0;
      bus_b.start_i = 0; bus_b.max_cycles_i = 0; bus_b.tests_passed_i = 0;
      bus_b.tests_failed_i = 0; bus_b.exit_valid_i = 0; bus_b.exit_value_i = 0;

      repeat (3) tick;
      chk_reset_vals("por");
      @(negedge core_clk) core_rst_n = 1'b1;
      tick;
      chk("idle_rst", 64'(bus_a.dut_rst_no), 64'd0);

      // Run 1: pass on the 5th RUN cycle
      start_seq("r1");
      repeat (4) tick;
      chk("r1_cnt4", 64'(bus_a.cycle_cnt_o), 64'd4);
      bus_a.tests_passed_i = 1'b1;
      tick;
      bus_a.tests_passed_i = 1'b0;
      chk("r1_done",   64'(bus_a.done_o),         64'd1);
      chk("r1_status", 64'(bus_a.status_o),       64'd1);
      chk("r1_cnt",    64'(bus_a.cycle_cnt_o),    64'd5);
      chk("r1_fetch",  64'(bus_a.fetch_enable_o), 64'd0);
      chk("r1_rst",    64'(bus_a.dut_rst_no),     64'd1);
      chk("r1_exit",   64'(bus_a.exit_value_o),   64'd0);
      bus_a.tests_failed_i = 1'b1;
      repeat (2) tick;
      bus_a.tests_failed_i = 1'b0;
      chk("r1_hold_status", 64'(bus_a.status_o),    64'd1);
      chk("r1_hold_cnt",    64'(bus_a.cycle_cnt_o), 64'd5);
      chk("r1_hold_done",   64'(bus_a.done_o),      64'd1);

      // Run 2: start ignored in RUN, then EXIT_ERR beats PASS
      start_seq("r2");
      bus_a.start_i = 1'b1;
      tick;
      bus_a.start_i = 1'b0;
      chk("r2_ign_fetch", 64'(bus_a.fetch_enable_o), 64'd1);
      chk("r2_ign_cnt",   64'(bus_a.cycle_cnt_o),    64'd1);
      chk("r2_ign_done",  64'(bus_a.done_o),         64'd0);
      bus_a.exit_valid_i = 1'b1; bus_a.exit_value_i = 32'h2A; bus_a.tests_passed_i = 1'b1;
      tick;
      bus_a.exit_valid_i = 1'b0; bus_a.exit_value_i = 32'h0; bus_a.tests_passed_i = 1'b0;
      chk("r2_status", 64'(bus_a.status_o),     64'd4);
      chk("r2_exit",   64'(bus_a.exit_value_o), 64'h2A);
      chk("r2_cnt",    64'(bus_a.cycle_cnt_o),  64'd2);

      // Run 3: exit with code 0
      start_seq("r3");
      bus_a.exit_valid_i = 1'b1;
      tick;
      bus_a.exit_valid_i = 1'b0;
      chk("r3_status", 64'(bus_a.status_o),     64'd3);
      chk("r3_exit",   64'(bus_a.exit_value_o), 64'd0);
      chk("r3_cnt",    64'(bus_a.cycle_cnt_o),  64'd1);

      // Run 4: FAIL beats a nonzero exit
      start_seq("r4");
      bus_a.tests_failed_i = 1'b1; bus_a.exit_valid_i = 1'b1; bus_a.exit_value_i = 32'h7;
      tick;
      bus_a.tests_failed_i = 1'b0; bus_a.exit_valid_i = 1'b0; bus_a.exit_value_i = 32'h0;
      chk("r4_status", 64'(bus_a.status_o),     64'd2);
      chk("r4_exit",   64'(bus_a.exit_value_o), 64'd0);

      // Run 5: timeout with budget 20
      bus_a.max_cycles_i = 32'd20;
      start_seq("r5");
      hi = 0;
      while (bus_a.fetch_enable_o === 1'b1 && hi < 40) begin
         hi++;
         tick;
      end
      chk("r5_fetch_hi", 64'(hi),                 64'd20);
      chk("r5_status",   64'(bus_a.status_o),     64'd5);
      chk("r5_cnt",      64'(bus_a.cycle_cnt_o),  64'd20);
      chk("r5_done",     64'(bus_a.done_o),       64'd1);

      // Run 6: event on the 20th cycle beats the timeout
      start_seq("r6");
      repeat (19) tick;
      chk("r6_cnt19", 64'(bus_a.cycle_cnt_o), 64'd19);
      bus_a.tests_passed_i = 1'b1;
      tick;
      bus_a.tests_passed_i = 1'b0;
      chk("r6_status", 64'(bus_a.status_o),    64'd1);
      chk("r6_cnt",    64'(bus_a.cycle_cnt_o), 64'd20);
      bus_a.max_cycles_i = 32'd0;

      // Run 7: asynchronous reset mid-RUN, then a full new sequence
      start_seq("r7");
      repeat (3) tick;
      #2 core_rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge core_clk) core_rst_n = 1'b1;
      tick;
      chk("r7_idle_rst", 64'(bus_a.dut_rst_no), 64'd0);
      start_seq("r7b");
      bus_a.tests_passed_i = 1'b1;
      tick;
      bus_a.tests_passed_i = 1'b0;
      chk("r7b_status", 64'(bus_a.status_o),    64'd1);
      chk("r7b_cnt",    64'(bus_a.cycle_cnt_o), 64'd1);

      // Run 8: start held high; done lasts a single cycle
      bus_a.start_i = 1'b1;
      tick;
      chk("r8_restart_done", 64'(bus_a.done_o),     64'd0);
      chk("r8_restart_rst",  64'(bus_a.dut_rst_no), 64'd0);
      repeat (7) tick;
      chk("r8_fetch", 64'(bus_a.fetch_enable_o), 64'd1);
      bus_a.tests_passed_i = 1'b1;
      tick;
      bus_a.tests_passed_i = 1'b0;
      chk("r8_done1",  64'(bus_a.done_o),   64'd1);
      chk("r8_status", 64'(bus_a.status_o), 64'd1);
      tick;
      chk("r8_done0",   64'(bus_a.done_o),     64'd0);
      chk("r8_status0", 64'(bus_a.status_o),   64'd0);
      chk("r8_rst0",    64'(bus_a.dut_rst_no), 64'd0);
      bus_a.start_i = 1'b0;

      // Zero fetch delay, two reset cycles
      bus_b.start_i = 1'b1;
      tick;
      bus_b.start_i = 1'b0;
      tick;
      chk("b_rst_held",   64'(bus_b.dut_rst_no),     64'd0);
      chk("b_fetch_held", 64'(bus_b.fetch_enable_o), 64'd0);
      tick;
      chk("b_rst_rise",   64'(bus_b.dut_rst_no),     64'd1);
      chk("b_fetch_rise", 64'(bus_b.fetch_enable_o), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
